// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: next-PC source encodings, fetch FSM
// state encodings, default NOP/reset values and a word-alignment helper.
package mips_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_J   = 2'b10,
    PCSRC_JR  = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selector (combinational).
// Ports:
//   pcsrc_i          2   source select (PCSRC_SEQ/BR/J/JR)
//   pcplus4_i        32  sequential successor of the current PC
//   branch_target_i  32  branch target
//   jump_addr_i      32  jump address (aligned by construction)
//   jr_target_i      32  jump-register target
//   next_pc_o        32  selected next PC, forced to a word boundary
//   misaligned_o     1   selected target had non-zero low bits
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [1:0]  pcsrc_i,
  input  logic [31:0] pcplus4_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jump_addr_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  logic [31:0] raw_pc;

  always_comb begin
    raw_pc = pcplus4_i;
    case (pcsrc_i)
      PCSRC_SEQ: raw_pc = pcplus4_i;
      PCSRC_BR:  raw_pc = branch_target_i;
      PCSRC_J:   raw_pc = jump_addr_i;
      PCSRC_JR:  raw_pc = jr_target_i;
      default:   raw_pc = pcplus4_i;
    endcase
  end

  assign next_pc_o    = align_word(raw_pc);
  assign misaligned_o = (raw_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection, IF/ID latch,
// BOOT/RUN/HALTED control FSM and a saturating fetch counter.
// Ports:
//   Clk, Reset (async, active-low)
//   Stall, PCSrc[1:0], BranchTarget, JumpAddress, JumpRegTarget, Halt, Instruction
//   PC, PCPlus4 (combinational), IFID_Instruction, IFID_PCPlus4, IFID_Valid
//   Halted, AddrError (sticky), FetchCount (saturating), DbgState (FSM state)
// Flow control: IFID_Valid qualifies IFID_Instruction/IFID_PCPlus4; while
// Stall is high (and no redirect) the PC and the whole IF/ID latch hold, so ID
// sees the same instruction again on the next cycle.
module pc_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] NOP_WORD     = DEFAULT_NOP_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpAddress,
  input  logic [31:0] JumpRegTarget,
  input  logic        Halt,
  input  logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic        AddrError,
  output logic [31:0] FetchCount,
  output logic [1:0]  DbgState
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d;
  logic [31:0]  ifid_pc4_q, ifid_pc4_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic         addr_err_q, addr_err_d;
  logic [31:0]  fcount_q, fcount_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_pc;
  logic         redirect_misaligned;

  // Wraps mod 2^32 with no error indication.
  assign pc_plus4 = pc_q + 32'd4;

  pc_next_sel u_next_sel (
    .pcsrc_i        (PCSrc),
    .pcplus4_i      (pc_plus4),
    .branch_target_i(BranchTarget),
    .jump_addr_i    (JumpAddress),
    .jr_target_i    (JumpRegTarget),
    .next_pc_o      (redirect_pc),
    .misaligned_o   (redirect_misaligned)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    addr_err_d   = addr_err_q;
    fcount_d     = fcount_q;
    case (state_q)
      ST_BOOT: begin
        // Single bubble cycle while the first imem read settles.
        ifid_instr_d = NOP_WORD;
        ifid_valid_d = 1'b0;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        if (PCSrc != PCSRC_SEQ) begin
          // The redirecting instruction is older than any stall or halt in ID.
          pc_d         = redirect_pc;
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
          if (redirect_misaligned) addr_err_d = 1'b1;
        end else if (Halt && ifid_valid_q) begin
          state_d      = ST_HALTED;
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
        end else if (!Stall) begin
          pc_d         = pc_plus4;
          ifid_instr_d = Instruction;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
          if (fcount_q != 32'hFFFF_FFFF) fcount_d = fcount_q + 32'd1;
        end
      end
      ST_HALTED: begin
        ifid_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      fcount_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      addr_err_q   <= addr_err_d;
      fcount_q     <= fcount_d;
    end
  end

  assign PC               = pc_q;
  assign PCPlus4          = pc_plus4;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PCPlus4     = ifid_pc4_q;
  assign IFID_Valid       = ifid_valid_q;
  assign Halted           = (state_q == ST_HALTED);
  assign AddrError        = addr_err_q;
  assign FetchCount       = fcount_q;
  assign DbgState         = state_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;
  import mips_pkg::*;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic [1:0]  PCSrc;
  logic [31:0] BranchTarget, JumpAddress, JumpRegTarget;
  logic        Halt;
  logic [31:0] Instruction;
  logic [31:0] PC, PCPlus4, IFID_Instruction, IFID_PCPlus4, FetchCount;
  logic        IFID_Valid, Halted, AddrError;
  logic [1:0]  DbgState;

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  pc_fetch_stage #(.RESET_VECTOR(RV), .NOP_WORD(NOP)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget), .JumpAddress(JumpAddress),
    .JumpRegTarget(JumpRegTarget), .Halt(Halt), .Instruction(Instruction),
    .PC(PC), .PCPlus4(PCPlus4), .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid), .Halted(Halted),
    .AddrError(AddrError), .FetchCount(FetchCount), .DbgState(DbgState)
  );

  // Instruction memory image: a fixed word at 0, address-derived words elsewhere.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : (a ^ 32'hDEAD_0000);
  endfunction

  assign Instruction = instr_at(PC);

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] ifp4;
    logic        valid;
    logic        halted;
    logic        aerr;
    logic [31:0] cnt;
    logic [1:0]  st;
  } exp_t;

  localparam int W = $bits(exp_t);
  logic [W-1:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model state
  fetch_state_e m_st;
  logic [31:0]  m_pc, m_instr, m_ifp4, m_cnt;
  logic         m_valid, m_aerr;

  task automatic model_reset();
    m_st = ST_BOOT; m_pc = RV; m_instr = NOP; m_ifp4 = 32'h0;
    m_valid = 1'b0; m_aerr = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic model_edge(input logic stall, input logic [1:0] src,
                            input logic [31:0] bt, input logic [31:0] ja,
                            input logic [31:0] jr, input logic halt);
    logic [31:0] tgt;
    case (m_st)
      ST_BOOT: begin
        m_instr = NOP; m_valid = 1'b0; m_st = ST_RUN;
      end
      ST_RUN: begin
        if (src != 2'b00) begin
          tgt = (src == 2'b01) ? bt : (src == 2'b10) ? ja : jr;
          if (tgt[1:0] != 2'b00) m_aerr = 1'b1;
          m_pc = {tgt[31:2], 2'b00};
          m_instr = NOP; m_valid = 1'b0;
        end else if (halt && m_valid) begin
          m_st = ST_HALTED; m_instr = NOP; m_valid = 1'b0;
        end else if (!stall) begin
          m_instr = instr_at(m_pc);
          m_ifp4  = m_pc + 32'd4;
          m_pc    = m_pc + 32'd4;
          m_valid = 1'b1;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
      end
      default: m_valid = 1'b0;
    endcase
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.instr = m_instr; e.ifp4 = m_ifp4;
    e.valid = m_valid; e.halted = (m_st == ST_HALTED); e.aerr = m_aerr;
    e.cnt = m_cnt; e.st = m_st;
    return e;
  endfunction

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_pc"},     PC, e.pc);
    check({tag, "_pcplus4"}, PCPlus4, e.pc4);
    check({tag, "_ifid_ins"}, IFID_Instruction, e.instr);
    check({tag, "_ifid_p4"}, IFID_PCPlus4, e.ifp4);
    check({tag, "_valid"},  {31'b0, IFID_Valid}, {31'b0, e.valid});
    check({tag, "_halted"}, {31'b0, Halted}, {31'b0, e.halted});
    check({tag, "_aerr"},   {31'b0, AddrError}, {31'b0, e.aerr});
    check({tag, "_fcount"}, FetchCount, e.cnt);
    check({tag, "_state"},  {30'b0, DbgState}, {30'b0, e.st});
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge or at a falling edge; applies one cycle of
  // inputs, predicts the post-edge state, then samples 1 ns after the edge.
  task automatic step(input string tag, input logic stall, input logic [1:0] src,
                      input logic [31:0] bt, input logic [31:0] ja,
                      input logic [31:0] jr, input logic halt);
    Stall = stall; PCSrc = src; BranchTarget = bt; JumpAddress = ja;
    JumpRegTarget = jr; Halt = halt;
    model_edge(stall, src, bt, ja, jr, halt);
    exp_q.push_back(model_snapshot());
    @(posedge Clk);
    #1;
    compare_outputs(tag);
  endtask

  task automatic seq(input string tag);
    step(tag, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r_bt, r_ja, r_jr, held_pc;
    int r;
    Reset = 1'b0; Stall = 1'b0; PCSrc = 2'b00; BranchTarget = 32'h0;
    JumpAddress = 32'h0; JumpRegTarget = 32'h0; Halt = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    check("rst_pc", PC, RV);
    check("rst_ifid_ins", IFID_Instruction, NOP);
    check("rst_ifid_p4", IFID_PCPlus4, 32'h0);
    check("rst_valid", {31'b0, IFID_Valid}, 32'd0);
    check("rst_halted", {31'b0, Halted}, 32'd0);
    check("rst_aerr", {31'b0, AddrError}, 32'd0);
    check("rst_fcount", FetchCount, 32'd0);
    Reset = 1'b1;

    // 1: boot bubble then first fetch
    seq("boot");
    check("boot_pc_lit", PC, 32'h0);
    seq("first_fetch");
    check("first_ins_lit", IFID_Instruction, 32'h2008_0005);
    check("first_pc_lit", PC, 32'h4);

    // 2: jump from 0x10 to 0x40
    seq("run_a"); seq("run_b"); seq("run_c");
    check("at_0x10", PC, 32'h10);
    step("jump", 1'b0, 2'b10, 32'h0, 32'h0000_0040, 32'h0, 1'b0);
    check("jump_pc_lit", PC, 32'h40);
    seq("after_jump");
    check("after_jump_p4_lit", IFID_PCPlus4, 32'h44);

    // 3: stall at 0x20, then branch while stalled
    step("br_1c", 1'b0, 2'b01, 32'h0000_001C, 32'h0, 32'h0, 1'b0);
    seq("to_0x20");
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    check("stall_pc_lit", PC, 32'h20);
    step("stall_br", 1'b1, 2'b01, 32'h0000_0080, 32'h0, 32'h0, 1'b0);

    // 4: PC wraps from 0xFFFF_FFFC
    step("jr_top", 1'b0, 2'b11, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0);
    check("wrap_pcplus4_lit", PCPlus4, 32'h0);
    seq("wrap");
    check("wrap_pc_lit", PC, 32'h0);

    // 5: misaligned jr is aligned and flagged; flag is sticky
    step("jr_mis", 1'b0, 2'b11, 32'h0, 32'h0, 32'h0000_0013, 1'b0);
    check("jr_mis_pc_lit", PC, 32'h10);
    check("jr_mis_aerr_lit", {31'b0, AddrError}, 32'd1);
    step("j_aligned", 1'b0, 2'b10, 32'h0, 32'h0000_0100, 32'h0, 1'b0);
    seq("sticky_seq");

    // 6: redirect beats halt, then halt freezes the stage
    step("halt_br", 1'b0, 2'b01, 32'h0000_0200, 32'h0, 32'h0, 1'b1);
    check("halt_br_halted_lit", {31'b0, Halted}, 32'd0);
    seq("pre_halt");
    step("halt", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
    check("halt_lit", {31'b0, Halted}, 32'd1);
    held_pc = m_pc;
    for (int i = 0; i < 10; i++)
      step("frozen", 1'(i % 2), 2'b10, 32'h0, 32'h0000_0300, 32'h0, 1'b0);
    check("frozen_pc_held", PC, held_pc);

    // asynchronous reset mid-cycle
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    check("async_pc", PC, RV);
    check("async_halted", {31'b0, Halted}, 32'd0);
    check("async_valid", {31'b0, IFID_Valid}, 32'd0);
    check("async_aerr", {31'b0, AddrError}, 32'd0);
    check("async_fcount", FetchCount, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    seq("reboot");

    // random traffic
    for (int i = 0; i < 60; i++) begin
      r    = $urandom_range(0, 9);
      r_bt = $urandom;
      r_ja = $urandom;
      r_ja[1:0] = 2'b00;
      r_jr = $urandom;
      step("rand", 1'($urandom_range(0, 3) == 0), (r < 7) ? 2'b00 : 2'(r - 6),
           r_bt, r_ja, r_jr, 1'($urandom_range(0, 19) == 0));
    end

    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
